// File: rtl/soundweb_tx_framer_pkg.sv
// soundweb_tx_framer_pkg: Soundweb control byte codes and the reserved-byte test shared by framer and decoders
package soundweb_tx_framer_pkg;
  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [7:0] ESC_ADD = 8'h80;
  function automatic logic is_reserved(input logic [7:0] value);
    return value == STX || value == ETX || value == ACK || value == NAK || value == ESC;
  endfunction
endpackage

// File: rtl/soundweb_escape.sv
// soundweb_escape: flags a reserved byte and forms its escaped substitute
module soundweb_escape
  import soundweb_tx_framer_pkg::*;
(
  input  logic [7:0] value,
  output logic       is_reserved,
  output logic [7:0] escaped_byte
);
  assign is_reserved = soundweb_tx_framer_pkg::is_reserved(value);
  assign escaped_byte = value + ESC_ADD;
endmodule

// File: rtl/soundweb_tx_framer.sv
// soundweb_tx_framer: frames one message as STX, stuffed body, stuffed XOR checksum, ETX with valid/ready
module soundweb_tx_framer
  import soundweb_tx_framer_pkg::*;
#(
  parameter int ADDR_BYTES = 6,
  parameter int SV_BYTES = 2,
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_command,
  input  logic [8*ADDR_BYTES-1:0] in_address,
  input  logic [8*SV_BYTES-1:0]   in_sv,
  input  logic [8*DATA_BYTES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_byte,
  output logic                    out_sop,
  output logic                    out_eop
);
  localparam int FIELD_BYTES = 1 + ADDR_BYTES + SV_BYTES + DATA_BYTES;
  localparam int IW = $clog2(FIELD_BYTES + 1);
  typedef enum logic [2:0] {IDLE, SEND_STX, SEND_BYTE, SEND_ESC, SEND_ETX} state_t;
  state_t state, state_n;
  logic [FIELD_BYTES-1:0][7:0] msg;
  logic [IW-1:0] idx, idx_n;
  logic [7:0] csum, csum_n, sel, esc_byte;
  logic rsv, last, accept;
  assign accept = in_valid && in_ready;
  assign last = idx == IW'(FIELD_BYTES);
  // the checksum slot follows the body, so one escape unit serves both
  assign sel = last ? csum : msg[idx];
  soundweb_escape u_escape (.value(sel), .is_reserved(rsv), .escaped_byte(esc_byte));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      csum <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      csum <= csum_n;
    end
    if (accept) msg <= {in_data, in_sv, in_address, in_command};
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    csum_n = csum;
    in_ready = state == IDLE && !reset;
    out_valid = state != IDLE;
    out_sop = state == SEND_STX;
    out_eop = state == SEND_ETX;
    out_byte = state == SEND_STX ? STX :
               state == SEND_BYTE ? (rsv ? ESC : sel) :
               state == SEND_ESC ? esc_byte :
               state == SEND_ETX ? ETX : 8'h00;
    // out_valid is high in every non-idle state, so out_ready alone marks a transfer
    case (state)
      IDLE: if (accept) begin
        state_n = SEND_STX;
        idx_n = '0;
        csum_n = '0;
      end
      SEND_STX: if (out_ready) state_n = SEND_BYTE;
      SEND_BYTE: if (out_ready) begin
        csum_n = last ? csum : csum ^ sel;
        state_n = rsv ? SEND_ESC : last ? SEND_ETX : SEND_BYTE;
        idx_n = rsv || last ? idx : idx + 1'b1;
      end
      SEND_ESC: if (out_ready) begin
        state_n = last ? SEND_ETX : SEND_BYTE;
        idx_n = last ? idx : idx + 1'b1;
      end
      SEND_ETX: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_soundweb_tx_framer.sv
// tb_soundweb_tx_framer: scoreboard bench; expected frames are built from accepted messages and popped per transfer
`timescale 1ns/1ps
module tb_soundweb_tx_framer;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  logic in_valid = 0, out_ready = 1, tog = 0;
  logic in_ready, out_valid, out_sop, out_eop;
  logic [7:0] in_command = 0, out_byte;
  logic [47:0] in_address = 0;
  logic [15:0] in_sv = 0;
  logic [31:0] in_data = 0;
  logic b_in_valid = 0;
  logic b_in_ready, b_out_valid, b_out_sop, b_out_eop;
  logic [7:0] b_in_sv = 0, b_in_data = 0, b_out_byte;
  int errs = 0, checks = 0, cyc = 0, n_xfer = 0, n_acc = 0, n_bacc = 0, flen = 0, b_len = 0;
  int etx_cyc = 0, acc_cyc = 0, sop_cyc = 0;
  logic [9:0] qa[$], qb[$];
  int lenq[$];
  logic stall = 0;
  logic [9:0] held = 0;

  soundweb_tx_framer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_command(in_command), .in_address(in_address), .in_sv(in_sv), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_sop(out_sop), .out_eop(out_eop)
  );

  soundweb_tx_framer #(.ADDR_BYTES(6), .SV_BYTES(1), .DATA_BYTES(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_command(in_command), .in_address(in_address), .in_sv(b_in_sv), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_byte(b_out_byte),
    .out_sop(b_out_sop), .out_eop(b_out_eop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rsv(input logic [7:0] b);
    return b == 8'h02 || b == 8'h03 || b == 8'h06 || b == 8'h15 || b == 8'h1B;
  endfunction

  task automatic push_frame(input logic [7:0] body[$], input bit to_b);
    logic [7:0] cs;
    logic [7:0] s[$];
    logic [9:0] f[$];
    cs = 0;
    foreach (body[i]) cs ^= body[i];
    s = body;
    s.push_back(cs);
    f.push_back({2'b10, 8'h02});
    foreach (s[i])
      if (rsv(s[i])) begin
        f.push_back({2'b00, 8'h1B});
        f.push_back({2'b00, s[i] + 8'h80});
      end else f.push_back({2'b00, s[i]});
    f.push_back({2'b01, 8'h03});
    if (to_b) foreach (f[i]) qb.push_back(f[i]);
    else begin
      foreach (f[i]) qa.push_back(f[i]);
      lenq.push_back(f.size());
    end
  endtask

  task automatic accept_a;
    logic [7:0] b[$];
    b.push_back(in_command);
    for (int i = 0; i < 6; i++) b.push_back(in_address[8*i +: 8]);
    for (int i = 0; i < 2; i++) b.push_back(in_sv[8*i +: 8]);
    for (int i = 0; i < 4; i++) b.push_back(in_data[8*i +: 8]);
    push_frame(b, 0);
    n_acc++;
    acc_cyc = cyc;
  endtask

  task automatic accept_b;
    logic [7:0] b[$];
    b.push_back(in_command);
    for (int i = 0; i < 6; i++) b.push_back(in_address[8*i +: 8]);
    b.push_back(b_in_sv);
    b.push_back(b_in_data);
    push_frame(b, 1);
    n_bacc++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) accept_a();
      if (out_valid) chk("in_ready_busy", in_ready, 0);
      if (stall && out_valid) chk("hold", {out_sop, out_eop, out_byte}, held);
      stall = out_valid && !out_ready;
      held = {out_sop, out_eop, out_byte};
      if (out_valid && out_ready) begin
        if (qa.size() == 0) chk("extra", out_valid, 0);
        else begin
          n_xfer++;
          flen = out_sop ? 1 : flen + 1;
          if (out_sop) sop_cyc = cyc;
          chk("byte", {out_sop, out_eop, out_byte}, qa.pop_front());
          if (out_eop) begin
            etx_cyc = cyc;
            if (lenq.size() > 0) chk("len", flen, lenq.pop_front());
          end
        end
      end
      if (b_in_valid && b_in_ready) accept_b();
      if (b_out_valid) begin
        b_len++;
        if (qb.size() == 0) chk("b_extra", b_out_valid, 0);
        else chk("b_byte", {b_out_sop, b_out_eop, b_out_byte}, qb.pop_front());
      end
    end else stall = 0;
  end

  task automatic send(input logic [7:0] c, input logic [47:0] a, input logic [15:0] s, input logic [31:0] d);
    int n;
    n = 0;
    in_command = c;
    in_address = a;
    in_sv = s;
    in_data = d;
    in_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (n >= 200) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while ((qa.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("done_timeout", qa.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (n_acc < target && n < 300) begin
      @(negedge clk);
      #1 n++;
    end
    if (n >= 300) chk("acc_timeout", n_acc, target);
  endtask

  initial begin
    int base, n, a2, e1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_ready", in_ready, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(8'h88, 0, 0, 0);
    wait_done();
    send(8'h02, 0, 0, 0);
    wait_done();
    send(8'h8D, 0, 0, 32'h1B00_0000);
    wait_done();
    send(8'h02, 48'h0302_1B15_0603, 16'h1506, 32'h0603_021B);
    wait_done();
    repeat (4) begin
      send(8'($urandom), 48'({$urandom, $urandom}), 16'($urandom), $urandom);
      wait_done();
    end
    tog = 1;
    fork
      while (tog) begin
        @(posedge clk);
        #1 if (tog) out_ready = ~out_ready;
      end
    join_none
    send(8'h88, 0, 0, 0);
    wait_done();
    tog = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    base = n_xfer;
    send(8'h5A, 48'h1, 16'h2, 32'h3);
    n = 0;
    while (n_xfer < base + 5 && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    if (n >= 100) chk("xfer_timeout", n_xfer, base + 5);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    qa.delete();
    lenq.delete();
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(8'h11, 48'h0203_0405_0607, 16'h1B00, 32'hA5A5_5A5A);
    wait_done();
    base = n_acc;
    in_command = 8'h88;
    in_address = 0;
    in_sv = 0;
    in_data = 0;
    in_valid = 1;
    wait_acc(base + 1);
    @(posedge clk);
    #1 in_command = 8'h15;
    in_data = 32'h0000_1B02;
    wait_acc(base + 2);
    a2 = acc_cyc;
    e1 = etx_cyc;
    @(posedge clk);
    #1 in_valid = 0;
    wait_done();
    chk("b2b_accept", a2 - e1, 1);
    chk("b2b_stx", sop_cyc - a2, 1);
    in_command = 8'h88;
    in_address = 0;
    b_len = 0;
    b_in_valid = 1;
    n = 0;
    while (n_bacc < 1 && n < 50) begin
      @(negedge clk);
      #1 n++;
    end
    if (n >= 50) chk("b_acc_timeout", n_bacc, 1);
    @(posedge clk);
    #1 b_in_valid = 0;
    n = 0;
    while ((qb.size() != 0 || !b_in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_len", b_len, 12);
    chk("b_drained", qb.size(), 0);
    chk("a_drained", qa.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
